// File: rtl/crc_mem_ctrl.sv
// crc_mem_ctrl -- sequencing controller placed directly in front of ram_8x4.
//
// Turns single requests into CRC-protected memory transactions:
//   write  : serially computes a 3-bit CRC of the 4-bit data word, then writes
//            the data word to {slot,0} and the zero-padded CRC to {slot,1}.
//   verify : reads both words back, recomputes the CRC over the data word and
//            reports a mismatch on crc_err together with the done pulse.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_write           : 1 = protected write, 0 = verify
//   req_slot, req_data  : target slot and data word (data ignored for verify)
//   mem_*               : address / data / strobes to ram_8x4, data_out back
//   done                : one-cycle completion pulse
//   rd_data, crc_err    : result of the last verify (crc_err cleared by writes)
//   err_count           : saturating count of failed verifies (optional)
//
// Optional feature: define CRC_MEM_ERRCNT_EN to add the err_count output.
`timescale 1ns/1ps
module crc_mem_ctrl #(
   parameter logic [3:0] POLY   = 4'b1001,
   parameter int         SLOT_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [SLOT_W-1:0] req_slot,
   input  logic [3:0]        req_data,
   output logic [2:0]        mem_address,
   output logic [3:0]        mem_data_in,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   input  logic [3:0]        mem_data_out,
   output logic              done,
   output logic [3:0]        rd_data,
`ifdef CRC_MEM_ERRCNT_EN
   output logic [7:0]        err_count,
`endif
   output logic              crc_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_CALC0, S_CALC1, S_CALC2, S_CALC3,
      S_WR_DATA, S_WR_CRC, S_RD_DATA, S_RD_CRC, S_RD_CAP, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              write_q, write_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [3:0]        data_q, data_d;
   logic [3:0]        stored_q, stored_d;
   logic [2:0]        rem_q, rem_d;
   logic [3:0]        rd_data_q, rd_data_d;
   logic              crc_err_q, crc_err_d;
`ifdef CRC_MEM_ERRCNT_EN
   logic [7:0]        err_count_q, err_count_d;
`endif

   // One serial CRC step, data MSB first; POLY[3] is the implicit x^3 term.
   function automatic logic [2:0] crc_step(input logic [2:0] rem, input logic d);
      logic fb;
      fb = rem[2] ^ d;
      return {rem[1:0], 1'b0} ^ (fb ? POLY[2:0] : 3'b000);
   endfunction

   always_comb begin
      state_d          = state_q;
      write_d          = write_q;
      slot_d           = slot_q;
      data_d           = data_q;
      stored_d         = stored_q;
      rem_d            = rem_q;
      rd_data_d        = rd_data_q;
      crc_err_d        = crc_err_q;
`ifdef CRC_MEM_ERRCNT_EN
      err_count_d      = err_count_q;
`endif
      mem_address      = 3'b000;
      mem_data_in      = 4'b0000;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      done             = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               slot_d  = req_slot;
               data_d  = req_data;
               rem_d   = 3'b000;
               state_d = req_write ? S_CALC0 : S_RD_DATA;
            end
         end
         S_CALC0: begin
            rem_d   = crc_step(rem_q, data_q[3]);
            state_d = S_CALC1;
         end
         S_CALC1: begin
            rem_d   = crc_step(rem_q, data_q[2]);
            state_d = S_CALC2;
         end
         S_CALC2: begin
            rem_d   = crc_step(rem_q, data_q[1]);
            state_d = S_CALC3;
         end
         S_CALC3: begin
            rem_d = crc_step(rem_q, data_q[0]);
            if (write_q) begin
               state_d = S_WR_DATA;
            end else begin
               // Verify results are registered here so they are visible
               // in the same cycle as the done pulse.
               state_d   = S_DONE;
               rd_data_d = data_q;
               crc_err_d = (stored_q != {1'b0, rem_d});
`ifdef CRC_MEM_ERRCNT_EN
               if ((stored_q != {1'b0, rem_d}) && (err_count_q != 8'hFF))
                  err_count_d = err_count_q + 8'd1;
`endif
            end
         end
         S_WR_DATA: begin
            mem_address      = {slot_q, 1'b0};
            mem_data_in      = data_q;
            mem_write_enable = 1'b1;
            state_d          = S_WR_CRC;
         end
         S_WR_CRC: begin
            mem_address      = {slot_q, 1'b1};
            mem_data_in      = {1'b0, rem_q};
            mem_write_enable = 1'b1;
            crc_err_d        = 1'b0;
            state_d          = S_DONE;
         end
         S_RD_DATA: begin
            mem_address     = {slot_q, 1'b0};
            mem_read_enable = 1'b1;
            state_d         = S_RD_CRC;
         end
         S_RD_CRC: begin
            // RAM output lags the address by one cycle: this is the data word.
            mem_address     = {slot_q, 1'b1};
            mem_read_enable = 1'b1;
            data_d          = mem_data_out;
            state_d         = S_RD_CAP;
         end
         S_RD_CAP: begin
            stored_d = mem_data_out;
            state_d  = S_CALC0;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign rd_data   = rd_data_q;
   assign crc_err   = crc_err_q;
`ifdef CRC_MEM_ERRCNT_EN
   assign err_count = err_count_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rd_data_q   <= 4'b0000;
         crc_err_q   <= 1'b0;
`ifdef CRC_MEM_ERRCNT_EN
         err_count_q <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         rd_data_q   <= rd_data_d;
         crc_err_q   <= crc_err_d;
`ifdef CRC_MEM_ERRCNT_EN
         err_count_q <= err_count_d;
`endif
      end
   end

   // Request context and CRC working registers carry no reset: they are
   // always loaded before use.
   always_ff @(posedge clk) begin
      write_q  <= write_d;
      slot_q   <= slot_d;
      data_q   <= data_d;
      stored_q <= stored_d;
      rem_q    <= rem_d;
   end

endmodule

// File: tb/tb_crc_mem_ctrl.sv
`timescale 1ns/1ps
module tb_crc_mem_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [1:0] req_slot;
   logic [3:0] req_data;
   logic [2:0] mem_address;
   logic [3:0] mem_data_in;
   logic       mem_write_enable;
   logic       mem_read_enable;
   logic [3:0] mem_data_out;
   logic       done;
   logic [3:0] rd_data;
   logic       crc_err;
`ifdef CRC_MEM_ERRCNT_EN
   logic [7:0] err_count;
`endif

   always #5 clk = ~clk;

   crc_mem_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_slot         (req_slot),
      .req_data         (req_data),
      .mem_address      (mem_address),
      .mem_data_in      (mem_data_in),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_data_out     (mem_data_out),
      .done             (done),
      .rd_data          (rd_data),
`ifdef CRC_MEM_ERRCNT_EN
      .err_count        (err_count),
`endif
      .crc_err          (crc_err)
   );

   // Behavioural ram_8x4 with a side port for planting corrupt words.
   logic [3:0] mem [8];
   logic       f_we = 1'b0;
   logic [2:0] f_addr = 3'd0;
   logic [3:0] f_din = 4'd0;
   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_address] <= mem_data_in;
      else if (f_we)        mem[f_addr]      <= f_din;
      if (mem_read_enable)  mem_data_out     <= mem[mem_address];
   end

   typedef struct {
      logic [3:0] rd;
      logic       err;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_hist[$];
   int   rd_hist[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   overlap_cnt = 0;
   int   wr67 = 0;
   logic ready_bad = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Edge-side observer: acceptances, read addresses, writes to slot 3.
   initial forever begin
      @(posedge clk);
      if (reset) acc_q.delete();
      else if (req_valid && req_ready) begin
         acc_q.push_back(cyc);
         acc_hist.push_back(cyc);
      end
      if (mem_read_enable) rd_hist.push_back(int'(mem_address));
      if (mem_write_enable && mem_address[2:1] == 2'b11) wr67++;
      cyc++;
   end

   // Scoreboard monitor: pops an expectation on every done pulse.
   initial forever begin
      exp_t e;
      int   lat;
      @(negedge clk);
      if (mem_write_enable && mem_read_enable) overlap_cnt++;
      if (acc_q.size() > 0 && req_ready) ready_bad = 1'b1;
      if (done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no completion");
         end else begin
            e   = exp_q.pop_front();
            lat = (acc_q.size() > 0) ? (cyc - acc_q.pop_front()) : -1;
            check("done_rd_data", rd_data, e.rd);
            check("done_crc_err", crc_err, e.err);
            check("done_latency", lat, e.lat);
            check("ready_low_while_busy", ready_bad, 0);
            ready_bad = 1'b0;
         end
      end
   end

   task automatic force_wr(input logic [2:0] a, input logic [3:0] d);
      @(negedge clk);
      f_we = 1'b1; f_addr = a; f_din = d;
      @(negedge clk);
      f_we = 1'b0;
   endtask

   task automatic wait_accept();
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         if (req_ready) got = 1;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL accept_timeout: got no acceptance expected acceptance within 40 cycles");
      end
   endtask

   task automatic push_exp(input logic [3:0] rd, input logic err, input int lat);
      exp_t e;
      e.rd = rd; e.err = err; e.lat = lat;
      exp_q.push_back(e);
   endtask

   // Issue one request; input fields are scrambled after acceptance.
   task automatic issue(input logic w, input logic [1:0] s, input logic [3:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_slot = s; req_data = d;
      wait_accept();
      @(negedge clk);
      req_valid = 1'b0; req_write = ~w; req_slot = ~s; req_data = ~d;
   endtask

   task automatic wait_done(input int target);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt >= target) got = 1;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL done_timeout: got %0d completions expected %0d", done_cnt, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, n, w;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_slot = 2'd0; req_data = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_done", done, 0);
      check("rst_crc_err", crc_err, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_mem_bus", {mem_address, mem_data_in, mem_write_enable, mem_read_enable}, 0);
`ifdef CRC_MEM_ERRCNT_EN
      check("rst_err_count", err_count, 0);
`endif
      reset = 1'b0;
      for (int a = 0; a < 8; a++) force_wr(3'(a), 4'd0);

      // Write slot 1, data 1111 -> CRC 110
      push_exp(4'h0, 1'b0, 7);
      issue(1'b1, 2'd1, 4'hF);
      wait_done(1);
      check("wr1_data_word", mem[2], 4'hF);
      check("wr1_crc_word", mem[3], 4'h6);

      // Verify slot 1
      h = rd_hist.size();
      push_exp(4'hF, 1'b0, 8);
      issue(1'b0, 2'd1, 4'h0);
      wait_done(2);
      check("vf1_read_count", rd_hist.size() - h, 2);
      if (rd_hist.size() >= h + 2) begin
         check("vf1_read_addr0", rd_hist[h], 2);
         check("vf1_read_addr1", rd_hist[h+1], 3);
      end

      // Write slot 2, data 1010 -> CRC 011, then corrupt CRC word to 0111
      push_exp(4'hF, 1'b0, 7);
      issue(1'b1, 2'd2, 4'hA);
      wait_done(3);
      check("wr2_crc_word", mem[5], 4'h3);
      force_wr(3'd5, 4'h7);
      push_exp(4'hA, 1'b1, 8);
      issue(1'b0, 2'd2, 4'h0);
      wait_done(4);
`ifdef CRC_MEM_ERRCNT_EN
      check("errcnt_after_vf2", err_count, 1);
`endif

      // Slot 0: data 0000 with stored CRC word 1000 (bit 3 set)
      force_wr(3'd0, 4'h0);
      force_wr(3'd1, 4'h8);
      push_exp(4'h0, 1'b1, 8);
      issue(1'b0, 2'd0, 4'h5);
      wait_done(5);
`ifdef CRC_MEM_ERRCNT_EN
      check("errcnt_after_vf0", err_count, 2);
`endif

      // Write clears crc_err; rd_data holds the last verify
      push_exp(4'h0, 1'b0, 7);
      issue(1'b1, 2'd0, 4'h0);
      wait_done(6);
      check("wr0_crc_word", mem[1], 4'h0);

      // Slot 3 (addresses 110/111): data 1100 -> CRC 101
      push_exp(4'h0, 1'b0, 7);
      issue(1'b1, 2'd3, 4'hC);
      wait_done(7);
      check("wr3_data_word", mem[6], 4'hC);
      check("wr3_crc_word", mem[7], 4'h5);
      push_exp(4'hC, 1'b0, 8);
      issue(1'b0, 2'd3, 4'h0);
      wait_done(8);

      // Reset during CALC2 of a write to slot 3
      force_wr(3'd6, 4'h9);
      force_wr(3'd7, 4'h9);
      w = wr67;
      issue(1'b1, 2'd3, 4'hF);     // returns at the negedge of CALC0
      @(negedge clk);              // CALC1
      @(negedge clk);              // CALC2
      reset = 1'b1;
      @(negedge clk);
      check("abort_req_ready", req_ready, 1);
      check("abort_strobes", {mem_write_enable, mem_read_enable, done}, 0);
      check("abort_crc_err", crc_err, 0);
`ifdef CRC_MEM_ERRCNT_EN
      check("abort_err_count", err_count, 0);
`endif
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_no_slot3_writes", wr67 - w, 0);
      check("abort_mem6", mem[6], 4'h9);
      check("abort_mem7", mem[7], 4'h9);
      check("abort_no_done", done_cnt, 8);

      // Back-to-back writes with req_valid held high
      n = acc_hist.size();
      push_exp(4'h0, 1'b0, 7);
      push_exp(4'h0, 1'b0, 7);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_slot = 2'd1; req_data = 4'hA;
      wait_accept();
      @(negedge clk);
      req_slot = 2'd2; req_data = 4'hF;
      wait_accept();
      @(negedge clk);
      req_valid = 1'b0;
      wait_done(10);
      check("b2b_accept_count", acc_hist.size() - n, 2);
      if (acc_hist.size() >= n + 2)
         check("b2b_accept_gap", acc_hist[n+1] - acc_hist[n], 8);
      check("b2b_slot1_data", mem[2], 4'hA);
      check("b2b_slot1_crc", mem[3], 4'h3);
      check("b2b_slot2_data", mem[4], 4'hF);
      check("b2b_slot2_crc", mem[5], 4'h6);
      check("strobe_overlap", overlap_cnt, 0);
      check("pending_expectations", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
